// File: rtl/mux4x2_8bits.sv
// mux4x2_8bits: packs 4 f-rate byte lanes onto 2 lanes at 2f (lane 00: in0,in1; lane 11: in2,in3)
//   clk_2f: sole clock; reset: async active-low
//   data_in0..3 / valid_in0..3: slow lanes, held for two clk_2f cycles
//   data_out00/11, valid_out00/11: fast lanes; phase_out 0 = lanes 0/2, 1 = lanes 1/3
module mux4x2_8bits #(
  parameter int BW = 8,
  parameter bit ZERO_INVALID = 1
) (
  input  logic          clk_2f,
  input  logic          reset,
  input  logic [BW-1:0] data_in0,
  input  logic [BW-1:0] data_in1,
  input  logic [BW-1:0] data_in2,
  input  logic [BW-1:0] data_in3,
  input  logic          valid_in0,
  input  logic          valid_in1,
  input  logic          valid_in2,
  input  logic          valid_in3,
  output logic [BW-1:0] data_out00,
  output logic [BW-1:0] data_out11,
  output logic          valid_out00,
  output logic          valid_out11,
  output logic          phase_out
);
  typedef enum logic {CAPTURE, EMIT1} state_t;
  state_t state;
  logic [1:0] sync;
  logic [3:0][BW:0] hold;
  logic [BW:0] out00, out11;
  // words are {data, valid}; invalid words lose their data when ZERO_INVALID is set
  function automatic logic [BW:0] gate(input logic [BW:0] w);
    return (ZERO_INVALID && !w[0]) ? '0 : w;
  endfunction
  assign {data_out00, valid_out00} = out00;
  assign {data_out11, valid_out11} = out11;
  // sync[1] is the release-synchronised run enable; first running edge is a CAPTURE
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      state <= CAPTURE;
      hold <= '0;
      out00 <= '0;
      out11 <= '0;
      phase_out <= 1'b0;
    end else begin
      sync <= {sync[0], 1'b1};
      if (sync[1]) begin
        if (state == CAPTURE) begin
          hold <= {{data_in3, valid_in3}, {data_in2, valid_in2}, {data_in1, valid_in1}, {data_in0, valid_in0}};
          out00 <= gate(hold[1]);
          out11 <= gate(hold[3]);
          phase_out <= 1'b1;
          state <= EMIT1;
        end else begin
          out00 <= gate(hold[0]);
          out11 <= gate(hold[2]);
          phase_out <= 1'b0;
          state <= CAPTURE;
        end
      end
    end
  end
endmodule

// File: tb/tb_mux4x2_8bits.sv
// tb_mux4x2_8bits: directed bench for mux4x2_8bits (dut_a ZERO_INVALID=1, dut_b ZERO_INVALID=0)
module tb_mux4x2_8bits;
  logic clk_2f = 1'b0;
  logic reset = 1'b0;
  logic [7:0] d0, d1, d2, d3;
  logic v0, v1, v2, v3;
  logic [7:0] a00, a11, b00, b11;
  logic av00, av11, bv00, bv11, aph, bph;
  logic [18:0] obs_a, obs_b, exp;
  int checks = 0;
  int errors = 0;
  always #5 clk_2f = ~clk_2f;
  mux4x2_8bits #(.BW(8), .ZERO_INVALID(1'b1)) dut_a (
    .clk_2f(clk_2f), .reset(reset),
    .data_in0(d0), .data_in1(d1), .data_in2(d2), .data_in3(d3),
    .valid_in0(v0), .valid_in1(v1), .valid_in2(v2), .valid_in3(v3),
    .data_out00(a00), .data_out11(a11), .valid_out00(av00), .valid_out11(av11), .phase_out(aph)
  );
  mux4x2_8bits #(.BW(8), .ZERO_INVALID(1'b0)) dut_b (
    .clk_2f(clk_2f), .reset(reset),
    .data_in0(d0), .data_in1(d1), .data_in2(d2), .data_in3(d3),
    .valid_in0(v0), .valid_in1(v1), .valid_in2(v2), .valid_in3(v3),
    .data_out00(b00), .data_out11(b11), .valid_out00(bv00), .valid_out11(bv11), .phase_out(bph)
  );
  assign obs_a = {a00, av00, a11, av11, aph};
  assign obs_b = {b00, bv00, b11, bv11, bph};
  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask
  task automatic drive(input logic [7:0] x0, x1, x2, x3, input logic [3:0] v);
    d0 = x0; d1 = x1; d2 = x2; d3 = x3;
    {v3, v2, v1, v0} = v;
  endtask
  // each scenario below starts and ends with the next edge being a CAPTURE edge
  task automatic test_reset();
    drive(8'h77, 8'h78, 8'h79, 8'h7A, 4'hF);
    reset = 1'b0;
    repeat (3) tick();
    exp = '0;
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL reset_hold_a got %h exp %h", obs_a, exp); end
    checks++; if (obs_b !== exp) begin errors++; $display("FAIL reset_hold_b got %h exp %h", obs_b, exp); end
    reset = 1'b1;
    tick();
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL sync_edge1 got %h exp %h", obs_a, exp); end
    tick();
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL sync_edge2 got %h exp %h", obs_a, exp); end
    tick();
    exp = {8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL first_capture got %h exp %h", obs_a, exp); end
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    tick();
    exp = {8'h77, 1'b1, 8'h79, 1'b1, 1'b0};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL first_emit got %h exp %h", obs_a, exp); end
  endtask
  task automatic test_single();
    drive(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'hF);
    tick();
    exp = {8'h78, 1'b1, 8'h7A, 1'b1, 1'b1};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL single_prev13 got %h exp %h", obs_a, exp); end
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    tick();
    exp = {8'hA0, 1'b1, 8'hA2, 1'b1, 1'b0};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL single_02 got %h exp %h", obs_a, exp); end
    tick();
    exp = {8'hA1, 1'b1, 8'hA3, 1'b1, 1'b1};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL single_13 got %h exp %h", obs_a, exp); end
    tick();
    exp = '0;
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL single_idle got %h exp %h", obs_a, exp); end
  endtask
  task automatic test_back_to_back();
    drive(8'h10, 8'h11, 8'h12, 8'h13, 4'hF);
    tick();
    tick();
    exp = {8'h10, 1'b1, 8'h12, 1'b1, 1'b0};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL b2b_1_02 got %h exp %h", obs_a, exp); end
    drive(8'h20, 8'h21, 8'h22, 8'h23, 4'hF);
    tick();
    exp = {8'h11, 1'b1, 8'h13, 1'b1, 1'b1};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL b2b_1_13 got %h exp %h", obs_a, exp); end
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    tick();
    exp = {8'h20, 1'b1, 8'h22, 1'b1, 1'b0};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL b2b_2_02 got %h exp %h", obs_a, exp); end
    tick();
    exp = {8'h21, 1'b1, 8'h23, 1'b1, 1'b1};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL b2b_2_13 got %h exp %h", obs_a, exp); end
    tick();
  endtask
  task automatic test_mixed_valid();
    drive(8'h40, 8'hFF, 8'h42, 8'h43, 4'b1101);
    tick();
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    tick();
    exp = {8'h40, 1'b1, 8'h42, 1'b1, 1'b0};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL mixed_02 got %h exp %h", obs_a, exp); end
    tick();
    exp = {8'h00, 1'b0, 8'h43, 1'b1, 1'b1};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL mixed_zero_inv got %h exp %h", obs_a, exp); end
    exp = {8'hFF, 1'b0, 8'h43, 1'b1, 1'b1};
    checks++; if (obs_b !== exp) begin errors++; $display("FAIL mixed_pass_inv got %h exp %h", obs_b, exp); end
    tick();
  endtask
  task automatic test_mid_reset();
    drive(8'h50, 8'h51, 8'h52, 8'h53, 4'hF);
    tick();
    tick();
    exp = {8'h50, 1'b1, 8'h52, 1'b1, 1'b0};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL midrst_02 got %h exp %h", obs_a, exp); end
    reset = 1'b0;
    #1;
    exp = '0;
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL midrst_async got %h exp %h", obs_a, exp); end
    tick();
    tick();
    drive(8'h60, 8'h61, 8'h62, 8'h63, 4'hF);
    reset = 1'b1;
    tick();
    tick();
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL midrst_sync got %h exp %h", obs_a, exp); end
    tick();
    exp = {8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL midrst_discard got %h exp %h", obs_a, exp); end
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    tick();
    exp = {8'h60, 1'b1, 8'h62, 1'b1, 1'b0};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL midrst_fresh02 got %h exp %h", obs_a, exp); end
    tick();
    exp = {8'h61, 1'b1, 8'h63, 1'b1, 1'b1};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL midrst_fresh13 got %h exp %h", obs_a, exp); end
    tick();
  endtask
  task automatic test_glitch();
    drive(8'h30, 8'h31, 8'h32, 8'h33, 4'hF);
    tick();
    d0 = 8'h55;
    tick();
    exp = {8'h30, 1'b1, 8'h32, 1'b1, 1'b0};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL glitch_02 got %h exp %h", obs_a, exp); end
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    tick();
    exp = {8'h31, 1'b1, 8'h33, 1'b1, 1'b1};
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL glitch_13 got %h exp %h", obs_a, exp); end
    tick();
    exp = '0;
    checks++; if (obs_a !== exp) begin errors++; $display("FAIL glitch_idle got %h exp %h", obs_a, exp); end
  endtask
  initial begin
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    test_reset();
    test_single();
    test_back_to_back();
    test_mixed_valid();
    test_mid_reset();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux4x2_8bits.md
Name: mux4x2_8bits

Overview:
- Transmit-side lane reducer: takes 4 parallel byte lanes (each with valid) at the slow rate f and emits them on 2 parallel lanes at rate 2f.
- Clocked by clk_2f only. Input lanes are held stable by the upstream for two clk_2f cycles, one f period.
- Output order per lane pair: lane 00 carries in0 then in1; lane 11 carries in2 then in3.
- Its output feeds the 2-lane path that a 2x4 demux on the receive side restores to 4 lanes.

Parameters:
- BW, 8, data width per lane in bits.
- ZERO_INVALID, 1, when 1 the data field of an output word is forced to 0 whenever its valid bit is 0; when 0 data passes through unmodified.

Ports:
- clk_2f  input  1  sole clock, twice the rate of the input lanes.
- reset  input  1  asynchronous, active-low (0 = in reset).
- data_in0, data_in1, data_in2, data_in3  input  BW each  slow-rate data lanes.
- valid_in0, valid_in1, valid_in2, valid_in3  input  1 each  valid per slow-rate lane.
- data_out00, data_out11  output  BW each  fast-rate data lanes.
- valid_out00, valid_out11  output  1 each  valid per fast-rate lane.
- phase_out  output  1  0 = output words currently carry lanes 0/2; 1 = they carry lanes 1/3.

Behaviour:
- Reset (reset=0, asynchronous assert): all outputs are 0 (data_out00/11, valid_out00/11, phase_out). Phase FSM goes to CAPTURE. Hold registers clear to 0.
- Reset release is synchronised internally with a 2-flop chain on clk_2f. The FSM runs only once the synchronised reset is high. Until then, outputs stay 0 and no capture occurs.
- FSM, 2 states, advances every clk_2f edge while out of reset:
  - CAPTURE -> EMIT1 -> CAPTURE -> ...
  - First running edge is always a CAPTURE edge.
- CAPTURE edge:
  - Load hold_k <= {data_ink, valid_ink} for k = 0..3.
  - Drive outputs from the previous hold contents of lanes 1/3: {data_out00, valid_out00} <= hold_1 and {data_out11, valid_out11} <= hold_3. Set phase_out <= 1.
  - On the very first CAPTURE after reset, hold is still 0, so the outputs stay 0.
- EMIT1 edge:
  - {data_out00, valid_out00} <= hold_0 (new); {data_out11, valid_out11} <= hold_2 (new). Set phase_out <= 0.
  - Hold registers keep their contents.
- Latency:
  - Inputs sampled at CAPTURE edge E.
  - Lanes 0/2 visible on the outputs after edge E+1.
  - Lanes 1/3 visible after edge E+2, coincident with the next capture.
  - Each output word is stable for exactly one clk_2f cycle.
- ZERO_INVALID=1: an output word with valid=0 has its data forced to 0 at register load. Valid bits are never altered.
- Inputs that change between CAPTURE edges are ignored. Only the CAPTURE-edge sample is used.
- Reset asserted mid-sequence, including between EMIT1 and the next CAPTURE: outputs go to 0 immediately (asynchronous). The pending hold_1/hold_3 words are discarded. After release the FSM restarts at CAPTURE.
- No backpressure. The block is free-running and the upstream must honour the 2-cycle hold.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with nonzero inputs -> all outputs 0 and phase_out=0. Release -> outputs remain 0 until the 2nd running edge after synchroniser latency.
2. Single word set, all valid: in0..3 = 0xA0, 0xA1, 0xA2, 0xA3, sampled at E -> after E+1: out00=0xA0, out11=0xA2, phase_out=0. After E+2: out00=0xA1, out11=0xA3, phase_out=1.
3. Back-to-back sets: 0x10–0x13 then 0x20–0x23 on consecutive f periods -> out00 sequence 0x10, 0x11, 0x20, 0x21 and out11 sequence 0x12, 0x13, 0x22, 0x23, with no gaps.
4. Mixed valid: valid_in1=0 with data_in1=0xFF, ZERO_INVALID=1 -> the lane-1 slot shows valid_out00=0 and data_out00=0x00. Rerun with ZERO_INVALID=0 -> data_out00=0xFF and valid_out00=0.
5. Mid-operation reset: assert reset the cycle after the EMIT1 edge, then release -> outputs 0 at once and the old lane-1/3 words never appear. The first post-release CAPTURE samples fresh inputs.
6. Input glitch: change data_in0 to 0x55 for the non-capture cycle only -> 0x55 never appears on out00.
